// File: rtl/pu_layer_sequencer_pkg.sv
// Shared state encoding and layer defaults for the PU sequencer and the top-level controller.
package pu_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StLoad  = 3'd2,
    StAcc   = 3'd3,
    StWrite = 3'd4,
    StDone  = 3'd5
  } seq_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  localparam int unsigned NUM_INPUTS      = 62;
  localparam int unsigned NUM_LANES       = 8;
  localparam int unsigned DEF_NUM_ROUNDS  = ceil_div(NUM_INPUTS, NUM_LANES);
  localparam int unsigned DEF_NUM_NEURONS = 30;
  localparam int unsigned DEF_MEM_LAT     = 1;
  localparam int unsigned DEF_IDX_W       = 5;

endpackage

// File: rtl/pu_layer_sequencer_if.sv
// Handshake with the layer controller plus control strobes to the PU datapath and memories.
interface pu_layer_sequencer_if #(
    parameter int unsigned IDX_W = 5
);
    logic             start;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] neuron_idx;
    logic             read_data_reg_ld;
    logic             acc_rst;
    logic             ld;
    logic [3:0]       round;
    logic             mult_done;
    logic             out_we;

    modport master (
        input  start,
        output busy, done, neuron_idx, read_data_reg_ld, acc_rst, ld, round, mult_done, out_we
    );

    modport slave (
        output start,
        input  busy, done, neuron_idx, read_data_reg_ld, acc_rst, ld, round, mult_done, out_we
    );
endinterface

// File: rtl/pu_round_counter.sv
// Loadable up-counter with a terminal-count flag; the owner stops incrementing at terminal count.
module pu_round_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (inc) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == term);

endmodule

// File: rtl/pu_layer_sequencer.sv
// Walks one PU datapath through every neuron of a layer: fetch, load, accumulate rounds, write.
module pu_layer_sequencer
    import pu_layer_sequencer_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int unsigned NUM_ROUNDS  = DEF_NUM_ROUNDS,
    parameter int unsigned MEM_LAT     = DEF_MEM_LAT,
    parameter int unsigned IDX_W       = DEF_IDX_W
) (
    input logic                  clk,
    input logic                  rst,
    pu_layer_sequencer_if.master bus
);

    // One counter serves both the FETCH wait and the ACC rounds; it must hold MEM_LAT-1.
    localparam int unsigned CNT_W = ($clog2(MEM_LAT) > 4) ? $clog2(MEM_LAT) : 4;

    seq_state_e state_q, state_d;

    logic             cnt_load, cnt_inc, cnt_tc;
    logic [CNT_W-1:0] cnt, cnt_term;
    logic             idx_load, idx_inc, idx_tc;
    logic [IDX_W-1:0] idx;

    pu_round_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .inc      (cnt_inc),
        .term     (cnt_term),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    pu_round_counter #(
        .WIDTH(IDX_W)
    ) u_idx (
        .clk      (clk),
        .rst      (rst),
        .load     (idx_load),
        .load_val ('0),
        .inc      (idx_inc),
        .term     (IDX_W'(NUM_NEURONS - 1)),
        .count    (idx),
        .tc       (idx_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        idx_load = 1'b0;
        idx_inc  = 1'b0;
        cnt_term = (state_q == StFetch) ? CNT_W'(MEM_LAT - 1) : CNT_W'(NUM_ROUNDS - 1);

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StFetch;
                    cnt_load = 1'b1;
                    idx_load = 1'b1;
                end
            end
            StFetch: begin
                if (cnt_tc) begin
                    state_d  = StLoad;
                    cnt_load = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StLoad: state_d = StAcc;
            StAcc: begin
                // Counter rests on the last round when leaving, so it never wraps.
                if (cnt_tc) begin
                    state_d = StWrite;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            StWrite: begin
                cnt_load = 1'b1;
                if (idx_tc) begin
                    state_d = StDone;
                end else begin
                    idx_inc = 1'b1;
                    state_d = StFetch;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.busy             = (state_q != StIdle);
    assign bus.done             = (state_q == StDone);
    assign bus.neuron_idx       = idx;
    assign bus.read_data_reg_ld = (state_q == StLoad);
    assign bus.acc_rst          = (state_q == StLoad);
    assign bus.ld               = (state_q == StAcc);
    assign bus.round            = (state_q == StAcc) ? cnt[3:0] : 4'd0;
    assign bus.mult_done        = (state_q == StAcc) && cnt_tc;
    assign bus.out_we           = (state_q == StWrite);

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Bench for pu_layer_sequencer: four configurations checked cycle by cycle against a timeline model.
module tb_pu_layer_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pu_layer_sequencer_if #(.IDX_W(5)) if_def ();
    pu_layer_sequencer_if #(.IDX_W(1)) if_one ();
    pu_layer_sequencer_if #(.IDX_W(2)) if_lat ();
    pu_layer_sequencer_if #(.IDX_W(2)) if_r1 ();

    pu_layer_sequencer #(.NUM_NEURONS(30), .NUM_ROUNDS(8), .MEM_LAT(1), .IDX_W(5))
        u_def (.clk(clk), .rst(rst), .bus(if_def));
    pu_layer_sequencer #(.NUM_NEURONS(1), .NUM_ROUNDS(8), .MEM_LAT(1), .IDX_W(1))
        u_one (.clk(clk), .rst(rst), .bus(if_one));
    pu_layer_sequencer #(.NUM_NEURONS(4), .NUM_ROUNDS(8), .MEM_LAT(3), .IDX_W(2))
        u_lat (.clk(clk), .rst(rst), .bus(if_lat));
    pu_layer_sequencer #(.NUM_NEURONS(3), .NUM_ROUNDS(1), .MEM_LAT(2), .IDX_W(2))
        u_r1 (.clk(clk), .rst(rst), .bus(if_r1));

    // Observation word: {busy, done, rdl, acc_rst, ld, mult_done, out_we, round[3:0], idx[7:0]}
    logic [18:0] obs [4];
    logic        start_v [4];

    assign obs[0] = {if_def.busy, if_def.done, if_def.read_data_reg_ld, if_def.acc_rst, if_def.ld,
                     if_def.mult_done, if_def.out_we, if_def.round, 8'(if_def.neuron_idx)};
    assign obs[1] = {if_one.busy, if_one.done, if_one.read_data_reg_ld, if_one.acc_rst, if_one.ld,
                     if_one.mult_done, if_one.out_we, if_one.round, 8'(if_one.neuron_idx)};
    assign obs[2] = {if_lat.busy, if_lat.done, if_lat.read_data_reg_ld, if_lat.acc_rst, if_lat.ld,
                     if_lat.mult_done, if_lat.out_we, if_lat.round, 8'(if_lat.neuron_idx)};
    assign obs[3] = {if_r1.busy, if_r1.done, if_r1.read_data_reg_ld, if_r1.acc_rst, if_r1.ld,
                     if_r1.mult_done, if_r1.out_we, if_r1.round, 8'(if_r1.neuron_idx)};

    assign if_def.start = start_v[0];
    assign if_one.start = start_v[1];
    assign if_lat.start = start_v[2];
    assign if_r1.start  = start_v[3];

    // Expected outputs t cycles after the cycle in which start was accepted (t >= 1).
    function automatic logic [18:0] model(input int nn, input int nr, input int lat, input int t);
        int   per, n, k;
        logic rdl, ld, md, we, dn;
        logic [3:0] rnd;
        logic [7:0] ix;
        per = lat + nr + 2;
        rdl = 0; ld = 0; md = 0; we = 0; dn = 0; rnd = 0;
        if (t == nn * per + 1) begin
            dn = 1;
            ix = 8'(nn - 1);
        end else begin
            n  = (t - 1) / per;
            k  = (t - 1) % per;
            ix = 8'(n);
            if (k == lat) rdl = 1;
            if (k > lat && k <= lat + nr) begin
                ld  = 1;
                rnd = 4'(k - lat - 1);
                md  = (k - lat - 1 == nr - 1);
            end
            if (k == lat + nr + 1) we = 1;
        end
        return {1'b1, dn, rdl, rdl, ld, md, we, rnd, ix};
    endfunction

    // Runs one layer on DUT id and records outputs for t = 1 .. len+1 (last is post-DONE idle).
    // mode 0: random start noise while busy; mode 1: start held for 50 cycles plus a later pulse.
    task automatic drive_layer(input int id, input int len, input int mode,
                               output logic [18:0] trace [$]);
        trace = {};
        @(negedge clk);
        start_v[id] = 1'b1;
        for (int t = 1; t <= len + 1; t++) begin
            @(negedge clk);
            if (mode == 1) start_v[id] = (t < len) && (t < 50 || t == 120);
            else           start_v[id] = (t < len) && ($urandom_range(0, 3) == 0);
            trace.push_back(obs[id]);
        end
        start_v[id] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
        #12;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (obs[i] !== 19'd0) begin
                n_err++;
                $display("FAIL reset dut%0d got=%h exp=%h", i, obs[i], 19'd0);
            end
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_neuron();
        logic [18:0] tr [$];
        int len = 1 * (1 + 8 + 2) + 1;
        drive_layer(1, len, 0, tr);
        for (int t = 1; t <= len; t++) begin
            n_cmp++;
            if (tr[t-1] !== model(1, 8, 1, t)) begin
                n_err++;
                $display("FAIL single_neuron t=%0d got=%h exp=%h", t, tr[t-1], model(1, 8, 1, t));
            end
        end
        n_cmp++;
        if (tr[len][18:8] !== 11'd0) begin
            n_err++;
            $display("FAIL single_neuron_idle got=%h exp=000", tr[len][18:8]);
        end
    endtask

    task automatic test_full_layer(input int mode, input string name);
        logic [18:0] tr [$];
        int len = 30 * 11 + 1;
        int we_c = 0, md_c = 0, ld_c = 0, dn_c = 0, done_t = 0;
        drive_layer(0, len, mode, tr);
        for (int t = 1; t <= len; t++) begin
            we_c += int'(tr[t-1][12]);
            md_c += int'(tr[t-1][13]);
            ld_c += int'(tr[t-1][14]);
            if (tr[t-1][17]) begin dn_c++; done_t = t; end
            n_cmp++;
            if (tr[t-1] !== model(30, 8, 1, t)) begin
                n_err++;
                $display("FAIL %s t=%0d got=%h exp=%h", name, t, tr[t-1], model(30, 8, 1, t));
            end
        end
        n_cmp++;
        if (we_c != 30 || md_c != 30 || ld_c != 240 || dn_c != 1 || done_t != 331) begin
            n_err++;
            $display("FAIL %s_counts got we=%0d md=%0d ld=%0d done=%0d@%0d exp 30/30/240/1@331",
                     name, we_c, md_c, ld_c, dn_c, done_t);
        end
        n_cmp++;
        if (tr[len][18:8] !== 11'd0) begin
            n_err++;
            $display("FAIL %s_idle got=%h exp=000", name, tr[len][18:8]);
        end
    endtask

    task automatic test_mem_lat_back_to_back();
        logic [18:0] tr [$];
        int len = 4 * (3 + 8 + 2) + 1;
        for (int run = 0; run < 2; run++) begin
            drive_layer(2, len, 0, tr);
            for (int t = 1; t <= len; t++) begin
                n_cmp++;
                if (tr[t-1] !== model(4, 8, 3, t)) begin
                    n_err++;
                    $display("FAIL mem_lat run%0d t=%0d got=%h exp=%h",
                             run, t, tr[t-1], model(4, 8, 3, t));
                end
            end
            n_cmp++;
            if (tr[len][18:8] !== 11'd0) begin
                n_err++;
                $display("FAIL mem_lat_idle run%0d got=%h exp=000", run, tr[len][18:8]);
            end
        end
    endtask

    task automatic test_one_round();
        logic [18:0] tr [$];
        int len = 3 * (2 + 1 + 2) + 1;
        drive_layer(3, len, 0, tr);
        for (int t = 1; t <= len; t++) begin
            n_cmp++;
            if (tr[t-1] !== model(3, 1, 2, t)) begin
                n_err++;
                $display("FAIL one_round t=%0d got=%h exp=%h", t, tr[t-1], model(3, 1, 2, t));
            end
        end
    endtask

    // Abort during neuron 5, round 3 (t = 1 + 5*11 + 1 + 1 + 3 = 61).
    task automatic test_reset_mid_layer();
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int t = 1; t <= 61; t++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            n_cmp++;
            if (obs[0] !== model(30, 8, 1, t)) begin
                n_err++;
                $display("FAIL reset_mid_pre t=%0d got=%h exp=%h", t, obs[0], model(30, 8, 1, t));
            end
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (obs[0] !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid_async got=%h exp=%h", obs[0], 19'd0);
        end
        @(negedge clk);
        n_cmp++;
        if (obs[0] !== 19'd0) begin
            n_err++;
            $display("FAIL reset_mid_held got=%h exp=%h", obs[0], 19'd0);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_neuron();
        test_full_layer(0, "full_layer");
        test_full_layer(1, "hold_start");
        test_mem_lat_back_to_back();
        test_one_round();
        test_reset_mid_layer();
        test_full_layer(0, "restart");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pu_layer_sequencer.md
Name: pu_layer_sequencer

Overview:
- Control FSM that drives one processing-unit datapath through a whole layer of neurons.
- For each neuron it:
  - presents the neuron index to the weight/input memories and waits out their read latency;
  - loads the 62-byte input and weight registers and clears the accumulator;
  - steps the 8-lane datapath through all rounds, adding the bias on the final round;
  - strobes the activated result out.
- Sits between the layer-level top controller (start/done handshake) and the PU datapath plus its memories.

Parameters:
- NUM_NEURONS, 30, neurons per layer; >=1.
- NUM_ROUNDS, 8, datapath rounds per neuron (ceil(62/8)); >=1, <=16.
- MEM_LAT, 1, cycles from neuron_idx change to valid memory data; >=1.
- IDX_W, 5, width of neuron_idx; must hold NUM_NEURONS-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after the last neuron is written.
- neuron_idx  out  IDX_W  memory read address of the current neuron.
- read_data_reg_ld  out  1  load datapath input/weight registers.
- acc_rst  out  1  clear datapath accumulator.
- ld  out  1  accumulator load enable.
- round  out  4  datapath round select.
- mult_done  out  1  final round: datapath adds bias into the accumulated sum.
- out_we  out  1  datapath activated output is valid; write it to result[neuron_idx].

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; counters 0. Reset mid-layer aborts immediately; no partial done or out_we.
- Outputs are Moore: decoded from state and counters, never from start.
- IDLE:
  - start=1 -> FETCH; neuron_idx=0; wait counter=0.
  - start=0 -> stay.
- FETCH:
  - neuron_idx is stable; count MEM_LAT cycles.
  - -> LOAD after the MEM_LAT-th cycle.
- LOAD (1 cycle):
  - read_data_reg_ld=1 and acc_rst=1 together; datapath registers capture at the end of this cycle.
  - round counter=0.
  - -> ACC.
- ACC (NUM_ROUNDS cycles):
  - ld=1; round=counter.
  - mult_done=1 only when counter==NUM_ROUNDS-1.
  - Counter increments each cycle.
  - -> WRITE after the final round.
- WRITE (1 cycle):
  - out_we=1; neuron_idx unchanged. The accumulator was updated at the end of the last ACC cycle and the activation is combinational, so out is valid here.
  - If neuron_idx==NUM_NEURONS-1 -> DONE.
  - Else neuron_idx+1 -> FETCH.
- DONE (1 cycle): done=1; -> IDLE. start during DONE is ignored.
- Outside ACC: round=0, ld=0, mult_done=0.
- Outside LOAD: read_data_reg_ld=0, acc_rst=0.
- start while busy is ignored; it is not queued.
- Per-neuron latency = MEM_LAT+1+NUM_ROUNDS+1 cycles; defaults give 11.
- Layer latency, start accepted to done = NUM_NEURONS*(MEM_LAT+NUM_ROUNDS+2)+1; defaults give 331.
- At most one of FETCH, LOAD, ACC, WRITE, DONE is active; out_we and done are never high in the same cycle.
- Counters never wrap: round saturates at NUM_ROUNDS-1 by FSM exit; neuron_idx never exceeds NUM_NEURONS-1.

Decomposition:
- Shared package: state encoding constants (IDLE, FETCH, LOAD, ACC, WRITE, DONE, 3 bits) and the layer defaults (62-input neuron, 8 lanes, NUM_ROUNDS=8), shared with the top-level controller.
- Sub-module: pu_round_counter, a generic loadable up-counter with terminal-count flag. It is instantiated twice: for FETCH wait/round counting and for neuron_idx.

Test Plan:
- NUM_NEURONS=1, MEM_LAT=1, start pulse at cycle 0 ->
  - FETCH cycle 1; LOAD cycle 2 (read_data_reg_ld=acc_rst=1);
  - ld=1 cycles 3-10 with round 0..7; mult_done=1 only at cycle 10;
  - out_we cycle 11; done cycle 12; busy 1-12.
- Defaults, full layer -> exactly 30 out_we pulses with neuron_idx 0..29 in order; done exactly 331 cycles after start is accepted; mult_done count=30; ld count=240.
- start held high for 50 cycles, then start pulsed mid-layer -> single layer run, no restart; done once; next start accepted only after return to IDLE.
- rst=0 asserted asynchronously during ACC of neuron 5, round 3 -> all outputs 0 immediately; state IDLE; a later start restarts from neuron_idx=0.
- MEM_LAT=3 -> neuron_idx stable 3 FETCH cycles before each LOAD; per-neuron period 13 cycles.
- NUM_ROUNDS=1 -> ACC is a single cycle with ld=1, round=0, mult_done=1.
